// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : Decode stage with 32-entry register file, immediate generation,
//             load-use stall and flush handling. Optional DECODE_ILLEGAL_EN.
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_decode,
    input  logic [31:0]     instr_decode,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            valid_exe,
    output logic [XLEN-1:0] pc_exe,
    output logic [XLEN-1:0] rs1_data_exe,
    output logic [XLEN-1:0] rs2_data_exe,
    output logic [XLEN-1:0] imm_exe,
    output logic [4:0]      rd_exe,
    output logic [6:0]      opcode_exe,
    output logic [2:0]      funct3_exe,
    output logic            funct7b5_exe,
    output logic            illegal_exe
);
    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_JALR   = 7'b1100111;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic [6:0] c_BRANCH = 7'b1100011;
    localparam logic [6:0] c_LUI    = 7'b0110111;
    localparam logic [6:0] c_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP     = 7'b0110011;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] rf_q [NUM_REGS];

    logic [6:0]      opcode_w;
    logic [4:0]      rs1_w, rs2_w, rd_w;
    logic [31:0]     imm32_w;
    logic [XLEN-1:0] imm_d, rs1_val_w, rs2_val_w;
    logic            use_rs1_w, use_rs2_w, hazard_w, issue_w;

    logic            valid_q;
    logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
    logic [4:0]      rd_q;
    logic [6:0]      opcode_q;
    logic [2:0]      funct3_q;
    logic            funct7b5_q;

    assign opcode_w = instr_decode[6:0];
    assign rs1_w    = instr_decode[19:15];
    assign rs2_w    = instr_decode[24:20];
    assign rd_w     = instr_decode[11:7];

    always_comb begin
        imm32_w = 32'd0;
        case (opcode_w)
            c_OP_IMM, c_LOAD, c_JALR: imm32_w = {{20{instr_decode[31]}}, instr_decode[31:20]};
            c_STORE:  imm32_w = {{20{instr_decode[31]}}, instr_decode[31:25], instr_decode[11:7]};
            c_BRANCH: imm32_w = {{19{instr_decode[31]}}, instr_decode[31], instr_decode[7],
                                 instr_decode[30:25], instr_decode[11:8], 1'b0};
            c_LUI, c_AUIPC: imm32_w = {instr_decode[31:12], 12'd0};
            c_JAL:    imm32_w = {{11{instr_decode[31]}}, instr_decode[31], instr_decode[19:12],
                                 instr_decode[20], instr_decode[30:21], 1'b0};
            default:  imm32_w = 32'd0;
        endcase
    end

    assign imm_d = {{(XLEN-31){imm32_w[31]}}, imm32_w[30:0]};

    // Write-through: a same-cycle writeback is visible to the reading instruction.
    always_comb begin
        rs1_val_w = '0;
        rs2_val_w = '0;
        if (rs1_w != 5'd0)
            rs1_val_w = (wb_en && wb_rd == rs1_w) ? wb_data : rf_q[rs1_w];
        if (rs2_w != 5'd0)
            rs2_val_w = (wb_en && wb_rd == rs2_w) ? wb_data : rf_q[rs2_w];
    end

    assign use_rs1_w = !(opcode_w == c_LUI || opcode_w == c_AUIPC || opcode_w == c_JAL);
    assign use_rs2_w = (opcode_w == c_OP) || (opcode_w == c_STORE) || (opcode_w == c_BRANCH);

    assign hazard_w = valid_q && (opcode_q == c_LOAD) && (rd_q != 5'd0) &&
                      ((use_rs1_w && rd_q == rs1_w) || (use_rs2_w && rd_q == rs2_w));

    always_comb begin
        state_d = ST_RUN;
        stall   = 1'b0;
        issue_w = 1'b1;
        if (flush) begin
            issue_w = 1'b0;
        end else if (state_q == ST_RUN && hazard_w) begin
            stall   = 1'b1;
            issue_w = 1'b0;
            state_d = ST_STALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    // On a bubble only valid drops; the payload holds its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
        end else if (issue_w) begin
            valid_q    <= 1'b1;
            pc_q       <= pc_decode;
            rs1_q      <= rs1_val_w;
            rs2_q      <= rs2_val_w;
            imm_q      <= imm_d;
            rd_q       <= rd_w;
            opcode_q   <= opcode_w;
            funct3_q   <= instr_decode[14:12];
            funct7b5_q <= instr_decode[30];
        end else begin
            valid_q    <= 1'b0;
        end
    end

`ifdef DECODE_ILLEGAL_EN
    logic illegal_d, illegal_q;

    always_comb begin
        illegal_d = 1'b1;
        case (opcode_w)
            c_OP_IMM, c_LOAD, c_JALR, c_STORE, c_BRANCH,
            c_LUI, c_AUIPC, c_JAL, c_OP: illegal_d = 1'b0;
            default:                     illegal_d = 1'b1;
        endcase
        if (instr_decode[1:0] != 2'b11) illegal_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          illegal_q <= 1'b0;
        else if (issue_w) illegal_q <= illegal_d;
        else              illegal_q <= 1'b0;
    end

    assign illegal_exe = illegal_q;
`else
    assign illegal_exe = 1'b0;
`endif

    assign valid_exe    = valid_q;
    assign pc_exe       = pc_q;
    assign rs1_data_exe = rs1_q;
    assign rs2_data_exe = rs2_q;
    assign imm_exe      = imm_q;
    assign rd_exe       = rd_q;
    assign opcode_exe   = opcode_q;
    assign funct3_exe   = funct3_q;
    assign funct7b5_exe = funct7b5_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : Scoreboard bench for decode_stage (honours DECODE_ILLEGAL_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_decode = '0, instr_decode = '0, wb_data = '0;
    logic        flush = 1'b0, wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        stall, valid_exe, funct7b5_exe, illegal_exe;
    logic [31:0] pc_exe, rs1_data_exe, rs2_data_exe, imm_exe;
    logic [4:0]  rd_exe;
    logic [6:0]  opcode_exe;
    logic [2:0]  funct3_exe;

    decode_stage #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .pc_decode(pc_decode), .instr_decode(instr_decode),
        .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .valid_exe(valid_exe), .pc_exe(pc_exe),
        .rs1_data_exe(rs1_data_exe), .rs2_data_exe(rs2_data_exe), .imm_exe(imm_exe),
        .rd_exe(rd_exe), .opcode_exe(opcode_exe), .funct3_exe(funct3_exe),
        .funct7b5_exe(funct7b5_exe), .illegal_exe(illegal_exe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_rf [32];
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [31:0] LW_X9      = 32'h0000A483; // lw  x9,0(x1)
    localparam logic [31:0] ADD_DEP    = 32'h00248533; // add x10,x9,x2
    localparam logic [31:0] ADD_IND    = 32'h00218533; // add x10,x3,x2
    localparam logic [31:0] LW_X11_X9  = 32'h0004A583; // lw  x11,0(x9)
    localparam logic [31:0] ADD_X12    = 32'h00058633; // add x12,x11,x0
    localparam exp_t        ZERO_EXP   = '0;
    localparam exp_t        BUBBLE_EXP = '0;

    function automatic exp_t observed();
        return {valid_exe, pc_exe, rs1_data_exe, rs2_data_exe, imm_exe, rd_exe,
                opcode_exe, funct3_exe, funct7b5_exe, illegal_exe};
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_rd == a) return wb_data;
        return ref_rf[a];
    endfunction

    // Reference decode of the word currently presented to the DUT.
    function automatic exp_t model();
        exp_t        e;
        logic [31:0] i;
        logic        known;
        i       = instr_decode;
        e       = '0;
        e.valid = 1'b1;
        e.pc    = pc_decode;
        e.rs1   = read_reg(i[19:15]);
        e.rs2   = read_reg(i[24:20]);
        e.rd    = i[11:7];
        e.op    = i[6:0];
        e.f3    = i[14:12];
        e.f7    = i[30];
        known   = 1'b1;
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: e.imm = $signed(i[31:20]);
            7'b0100011: e.imm = $signed({i[31:25], i[11:7]});
            7'b1100011: e.imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
            7'b0110111, 7'b0010111: e.imm = {i[31:12], 12'h000};
            7'b1101111: e.imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            7'b0110011: e.imm = 32'd0;
            default: begin e.imm = 32'd0; known = 1'b0; end
        endcase
`ifdef DECODE_ILLEGAL_EN
        e.ill = !known || (i[1:0] != 2'b11);
`else
        e.ill = 1'b0;
`endif
        return e;
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic fl,
                         input logic wen, input logic [4:0] wrd, input logic [31:0] wdat);
        pc_decode = pc; instr_decode = ins; flush = fl;
        wb_en = wen; wb_rd = wrd; wb_data = wdat;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (wb_en && wb_rd != 5'd0) ref_rf[wb_rd] = wb_data;
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        for (int k = 0; k < 32; k++) ref_rf[k] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        o = observed(); n_cmp++;
        if (o !== ZERO_EXP) begin n_bad++; $display("FAIL reset_held: got %h want %h", o, ZERO_EXP); end
        @(negedge clk); rst = 1'b0;
        drive(32'h40, 32'h00000013, 0, 0, 0, 0);
        sb.push_back(model()); tick();
        e = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_first_issue: got %h want %h", o, e); end
        #2 rst = 1'b1;
        #1;
        o = observed(); n_cmp++;
        if (o !== ZERO_EXP) begin n_bad++; $display("FAIL reset_async: got %h want %h", o, ZERO_EXP); end
        for (int k = 0; k < 32; k++) ref_rf[k] = 32'd0;
        @(negedge clk); rst = 1'b0;
        drive(32'h44, 32'h00000013, 0, 1, 5'd5, 32'h1234);
        sb.push_back(model()); tick();
        e = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_wb_x5: got %h want %h", o, e); end
        drive(32'h48, 32'hFFF28313, 0, 0, 0, 0);
        sb.push_back(model()); tick();
        e = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL addi_x6: got %h want %h", o, e); end
        n_cmp++;
        if ({valid_exe, rs1_data_exe, imm_exe, rd_exe} !== {1'b1, 32'h1234, 32'hFFFFFFFF, 5'd6}) begin
            n_bad++;
            $display("FAIL addi_fields: got v=%b rs1=%h imm=%h rd=%0d want v=1 rs1=00001234 imm=ffffffff rd=6",
                     valid_exe, rs1_data_exe, imm_exe, rd_exe);
        end
    endtask

    task automatic test_bypass();
        exp_t e, o;
        drive(32'h80, 32'h00038433, 0, 1, 5'd7, 32'hDEADBEEF);
        sb.push_back(model()); tick();
        e = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL bypass_add: got %h want %h", o, e); end
        n_cmp++;
        if ({rs1_data_exe, rs2_data_exe} !== {32'hDEADBEEF, 32'h0}) begin
            n_bad++; $display("FAIL bypass_ops: got %h/%h want deadbeef/00000000", rs1_data_exe, rs2_data_exe);
        end
        drive(32'h84, 32'h00000433, 0, 1, 5'd0, 32'hFFFF_FFFF);
        sb.push_back(model()); tick();
        e = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL x0_bypass: got %h want %h", o, e); end
        drive(32'h88, 32'h00000433, 0, 0, 0, 0);
        sb.push_back(model()); tick();
        e = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== e || rs1_data_exe !== 32'd0) begin
            n_bad++; $display("FAIL x0_read: got %h want %h", o, e);
        end
    endtask

    task automatic test_load_use();
        exp_t e, o;
        drive(32'h200, LW_X9, 0, 0, 0, 0);
        sb.push_back(model()); tick();
        e = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL lu_load: got %h want %h", o, e); end
        drive(32'h204, ADD_DEP, 0, 0, 0, 0);
        n_cmp++;
        if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", stall); end
        sb.push_back(BUBBLE_EXP); tick();
        e = sb.pop_front(); n_cmp++;
        if ({valid_exe, illegal_exe} !== {e.valid, e.ill}) begin
            n_bad++; $display("FAIL lu_bubble: got valid=%b want %b", valid_exe, e.valid);
        end
        drive(32'h204, ADD_DEP, 0, 0, 0, 0);
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_once: got %b want 0", stall); end
        sb.push_back(model()); tick();
        e = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL lu_add_issue: got %h want %h", o, e); end
        drive(32'h208, LW_X9, 0, 0, 0, 0);
        sb.push_back(model()); tick();
        e = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL lu_load2: got %h want %h", o, e); end
        drive(32'h20C, ADD_IND, 0, 0, 0, 0);
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_no_dep_stall: got %b want 0", stall); end
        sb.push_back(model()); tick();
        e = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL lu_no_dep_issue: got %h want %h", o, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog [3];
        logic        exp_stall [3];
        exp_t        e, o;
        prog = '{LW_X9, LW_X11_X9, ADD_X12};
        exp_stall = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            drive(32'h300 + 32'(4 * k), prog[k], 0, 0, 0, 0);
            n_cmp++;
            if (stall !== exp_stall[k]) begin
                n_bad++; $display("FAIL b2b_stall[%0d]: got %b want %b", k, stall, exp_stall[k]);
            end
            if (exp_stall[k]) begin
                sb.push_back(BUBBLE_EXP); tick();
                e = sb.pop_front(); n_cmp++;
                if (valid_exe !== e.valid) begin
                    n_bad++; $display("FAIL b2b_bubble[%0d]: got valid=%b want 0", k, valid_exe);
                end
                drive(32'h300 + 32'(4 * k), prog[k], 0, 0, 0, 0);
                n_cmp++;
                if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_restall[%0d]: got %b want 0", k, stall); end
            end
            sb.push_back(model()); tick();
            e = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL b2b_issue[%0d]: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_flush();
        exp_t e, o;
        drive(32'h400, LW_X9, 0, 0, 0, 0);
        sb.push_back(model()); tick();
        e = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL fl_load: got %h want %h", o, e); end
        drive(32'h404, ADD_DEP, 1, 0, 0, 0);
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL fl_stall: got %b want 0", stall); end
        sb.push_back(BUBBLE_EXP); tick();
        e = sb.pop_front(); n_cmp++;
        if ({valid_exe, illegal_exe} !== {e.valid, e.ill}) begin
            n_bad++; $display("FAIL fl_bubble: got valid=%b want 0", valid_exe);
        end
        drive(32'h500, ADD_IND, 0, 0, 0, 0);
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL fl_after_stall: got %b want 0", stall); end
        sb.push_back(model()); tick();
        e = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL fl_next_issue: got %h want %h", o, e); end
        drive(32'h504, LW_X9, 0, 0, 0, 0);
        sb.push_back(model()); tick();
        void'(sb.pop_front());
        drive(32'h508, ADD_DEP, 0, 0, 0, 0);
        n_cmp++;
        if (stall !== 1'b1) begin n_bad++; $display("FAIL fl_run_state: got stall=%b want 1", stall); end
        sb.push_back(BUBBLE_EXP); tick();
        void'(sb.pop_front());
    endtask

    task automatic test_immediates();
        logic [31:0] ins [4];
        logic [31:0] imm [4];
        exp_t        e, o;
        ins = '{32'hFE000EE3, 32'h800000EF, 32'hFE112E23, 32'h123452B7};
        imm = '{32'hFFFFFFFC, 32'hFFF00000, 32'hFFFFFFFC, 32'h12345000};
        for (int k = 0; k < 4; k++) begin
            drive(32'h600 + 32'(4 * k), ins[k], 0, 0, 0, 0);
            sb.push_back(model()); tick();
            e = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL imm_decode[%0d]: got %h want %h", k, o, e); end
            n_cmp++;
            if (imm_exe !== imm[k]) begin
                n_bad++; $display("FAIL imm_value[%0d]: got %h want %h", k, imm_exe, imm[k]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [2];
        logic        ill [2];
        exp_t        e, o;
        ins = '{32'h00000000, 32'h00000013};
`ifdef DECODE_ILLEGAL_EN
        ill = '{1'b1, 1'b0};
`else
        ill = '{1'b0, 1'b0};
`endif
        for (int k = 0; k < 2; k++) begin
            drive(32'h700 + 32'(4 * k), ins[k], 0, 0, 0, 0);
            sb.push_back(model()); tick();
            e = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL ill_decode[%0d]: got %h want %h", k, o, e); end
            n_cmp++;
            if (illegal_exe !== ill[k]) begin
                n_bad++; $display("FAIL ill_flag[%0d]: got %b want %b", k, illegal_exe, ill[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_immediates();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
